// File: rtl/ureg_pkg.sv
// ureg_pkg: mode/state encodings and per-mode data-cycle count for the universal shift register sequencer.
package ureg_pkg;
    typedef enum logic [1:0] {PIPO = 2'd0, SIPO = 2'd1, SISO = 2'd2, PISO = 2'd3} ureg_mode_e;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_e;

    function automatic int unsigned n_cycles(input ureg_mode_e m, input int unsigned dw);
        return (m == PIPO) ? 1 : dw;
    endfunction
endpackage

// File: rtl/ureg_capture.sv
// ureg_capture: result register with parallel load and LSB-side serial shift-in.
module ureg_capture #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic [DW-1:0] par_i,
    input  logic          ser_i,
    output logic [DW-1:0] q_o
);
    logic [DW-1:0] q_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q_q <= '0;
        else if (load_i)
            q_q <= par_i;
        else if (shift_i)
            q_q <= {q_q[DW-2:0], ser_i};

    assign q_o = q_q;
endmodule

// File: rtl/ureg_sequencer.sv
// ureg_sequencer: runs one command through the universal shift register and returns its output word.
module ureg_sequencer
    import ureg_pkg::*;
#(
    parameter int DW      = 4,
    parameter int REG_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          abort,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic          cmd_dir,
    input  logic [DW-1:0] cmd_data,
    output logic          reg_enb,
    output logic          reg_l_s,
    output logic [1:0]    reg_selector,
    output logic          reg_left_right,
    output logic [DW-1:0] reg_inp,
    input  logic [DW-1:0] reg_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy
);
    localparam int CW = $clog2(DW + REG_LAT + 1);
    localparam int IW = $clog2(DW);

    state_e        state_q, state_d;
    logic [CW-1:0] k_q, k_d, last_k;
    ureg_mode_e    mode_q;
    logic          dir_q;
    logic [DW-1:0] data_q;
    logic [IW-1:0] k_lo, idx;
    logic          run, last, par_mode, ser_bit;

    assign run      = state_q == RUN;
    assign last_k   = CW'(n_cycles(mode_q, DW) + REG_LAT - 1);
    assign last     = k_q == last_k;
    assign par_mode = mode_q == PIPO || mode_q == PISO;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid ? RUN : IDLE;
            RUN:     state_d = abort ? IDLE : last ? RESP : RUN;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    assign k_d = (run && !last && !abort) ? k_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            mode_q  <= PIPO;
            dir_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (cmd_valid && cmd_ready) begin
                mode_q <= ureg_mode_e'(cmd_mode);
                dir_q  <= cmd_dir;
                data_q <= cmd_data;
            end
        end

    // serial source walks MSB-first for dir=0, LSB-first for dir=1
    assign k_lo    = k_q[IW-1:0];
    assign idx     = dir_q ? k_lo : IW'(DW - 1) - k_lo;
    assign ser_bit = (k_q < CW'(DW)) && data_q[idx];

    assign cmd_ready      = state_q == IDLE;
    assign busy           = !cmd_ready;
    assign rsp_valid      = state_q == RESP;
    assign reg_enb        = run && !last;
    assign reg_l_s        = run && mode_q == PISO && k_q == '0;
    assign reg_selector   = run ? 2'(mode_q) : 2'b00;
    assign reg_left_right = run && dir_q;
    assign reg_inp        = !run ? '0 : par_mode ? data_q : {ser_bit, {(DW-1){1'b0}}};

    ureg_capture #(.DW(DW)) u_cap (
        .clk    (clk),
        .rst    (rst),
        .load_i (run && last && (mode_q == PIPO || mode_q == SIPO)),
        .shift_i(run && (mode_q == SISO || mode_q == PISO) &&
                 k_q >= CW'(REG_LAT) && k_q < CW'(REG_LAT + DW)),
        .par_i  (reg_out),
        .ser_i  (reg_out[DW-1]),
        .q_o    (rsp_data)
    );
endmodule

// File: tb/tb_ureg_sequencer.sv
// tb_ureg_sequencer: directed transfers against a behavioural two-stage universal shift register.
module tb_ureg_sequencer;
    logic       clk = 1'b0, rst = 1'b1, abort = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, rsp_ready = 1'b0;
    logic [1:0] cmd_mode = 2'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       cmd_ready, reg_enb, reg_l_s, reg_left_right, rsp_valid, busy;
    logic [1:0] reg_selector;
    logic [3:0] reg_inp, reg_out, rsp_data, r_q, out_q;
    int         vectors = 0, errs = 0;

    always #5 clk = ~clk;

    ureg_sequencer #(.DW(4), .REG_LAT(2)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_dir(cmd_dir), .cmd_data(cmd_data),
        .reg_enb(reg_enb), .reg_l_s(reg_l_s), .reg_selector(reg_selector), .reg_left_right(reg_left_right),
        .reg_inp(reg_inp), .reg_out(reg_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    // register model: enabled update of r_q, then one free-running output stage (latency 2)
    always @(posedge clk or negedge rst)
        if (!rst) begin
            r_q   <= 4'd0;
            out_q <= 4'd0;
        end else begin
            out_q <= r_q;
            if (reg_enb)
                r_q <= (reg_selector == 2'd0 || (reg_selector == 2'd3 && reg_l_s)) ? reg_inp :
                       reg_left_right ? {reg_inp[3], r_q[3:1]} : {r_q[2:0], reg_inp[3]};
        end
    assign reg_out = out_q;

    // {busy, cmd_ready, rsp_valid, reg_enb, reg_l_s, reg_left_right, reg_selector, reg_inp, rsp_data}
    function automatic logic [15:0] snap();
        return {busy, cmd_ready, rsp_valid, reg_enb, reg_l_s, reg_left_right, reg_selector, reg_inp, rsp_data};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic d, input logic [3:0] w);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_dir   = d;
        cmd_data  = w;
        tick;
        cmd_valid = 1'b0;
        cmd_data  = 4'd0;
    endtask

    task automatic steps(input string tag, input int n, input logic [127:0] s);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick;
            chk($sformatf("%s_k%0d", tag, i), snap(), s[127:112]);
            s = s << 16;
        end
    endtask

    task automatic handshake(input string tag, input logic [15:0] exp);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk(tag, snap(), exp);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2 chk("reset_async", snap(), 16'h4000);
        #9 rst = 1'b1;
        tick;
        chk("reset_idle", snap(), 16'h4000);

        send(2'd0, 1'b0, 4'hA);
        steps("pipo", 4, {16'h90A0, 16'h90A0, 16'h80A0, 16'hA00A, 64'h0});
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_in_resp", snap(), 16'hA00A);
        handshake("pipo_done", 16'h400A);

        send(2'd1, 1'b0, 4'b1011);
        steps("sipo", 7, {16'h918A, 16'h910A, 16'h918A, 16'h918A, 16'h910A, 16'h810A, 16'hA00B, 16'h0});
        handshake("sipo_done", 16'h400B);

        send(2'd3, 1'b0, 4'hC);
        steps("piso", 7, {16'h9BCB, 16'h93CB, 16'h93CB, 16'h93C7, 16'h93CF, 16'h83CE, 16'hA00C, 16'h0});
        handshake("piso_done", 16'h400C);

        send(2'd2, 1'b1, 4'b0001);
        steps("siso", 7, {16'h968C, 16'h960C, 16'h960C, 16'h9609, 16'h9602, 16'h8604, 16'hA008, 16'h0});
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i % 2) == 0;
            cmd_mode  = 2'd0;
            cmd_data  = 4'hF;
            tick;
            chk($sformatf("rsp_hold_%0d", i), snap(), 16'hA008);
        end
        cmd_valid = 1'b0;
        cmd_data  = 4'd0;
        handshake("siso_done", 16'h4008);
        tick;
        chk("no_queued_cmd", snap(), 16'h4008);
        rsp_ready = 1'b1;
        abort     = 1'b1;
        tick;
        rsp_ready = 1'b0;
        abort     = 1'b0;
        chk("idle_ignores_ready_abort", snap(), 16'h4008);

        send(2'd1, 1'b0, 4'b0110);
        steps("sipo_abort", 3, {16'h9108, 16'h9188, 16'h9188, 80'h0});
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_idle", snap(), 16'h4008);
        tick;
        chk("abort_no_rsp", snap(), 16'h4008);

        send(2'd0, 1'b0, 4'h5);
        steps("pipo_after_abort", 4, {16'h9058, 16'h9058, 16'h8058, 16'hA005, 64'h0});
        handshake("pipo5_done", 16'h4005);

        send(2'd3, 1'b0, 4'h9);
        steps("piso_rst", 2, {16'h9B95, 16'h9395, 96'h0});
        #2 rst = 1'b0;
        #1 chk("rst_mid_xfer", snap(), 16'h4000);
        #2 rst = 1'b1;
        tick;
        chk("rst_release", snap(), 16'h4000);

        send(2'd0, 1'b1, 4'h3);
        steps("pipo_right", 4, {16'h9430, 16'h9430, 16'h8430, 16'hA003, 64'h0});
        handshake("pipo3_done", 16'h4003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
